// File: rtl/seg7_mux_scan_driver.sv
// seg7_mux_scan_driver: time-multiplexed N-digit hex 7-segment driver with guard, lzb, polarity and frame-synchronous update
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   enable          1 = scanning, 0 = display dark (loads still accepted)
//   load            1-cycle strobe capturing value/dp_mask into the pending buffer
//   value, dp_mask  hex digits (digit 0 = bits [3:0]) and per-digit decimal points
//   lzb             leading-zero blanking enable
//   seg, dp, an     registered display pins, polarity set by parameters
//   digit_idx       digit currently scanned
//   frame_done      1-cycle pulse after the scan wraps to digit 0
//   pending         loaded data waiting for the next frame boundary
module seg7_mux_scan_driver #(
    parameter int NUM_DIGITS     = 4,
    parameter int CLK_DIV        = 50000,
    parameter int GUARD          = 16,
    parameter int SEG_ACTIVE_LOW = 0,
    parameter int AN_ACTIVE_LOW  = 0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       enable,
    input  logic                       load,
    input  logic [4*NUM_DIGITS-1:0]    value,
    input  logic [NUM_DIGITS-1:0]      dp_mask,
    input  logic                       lzb,
    output logic [6:0]                 seg,
    output logic                       dp,
    output logic [NUM_DIGITS-1:0]      an,
    output logic [(NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1)-1:0] digit_idx,
    output logic                       frame_done,
    output logic                       pending
);
    localparam int IW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;
    localparam int PW = $clog2(CLK_DIV);
    localparam logic [111:0] SEG_LUT = {
        7'b1000111, 7'b1001111, 7'b0111101, 7'b1001110,
        7'b0011111, 7'b1110111, 7'b1111011, 7'b1111111,
        7'b1110000, 7'b1011111, 7'b1011011, 7'b0110011,
        7'b1111001, 7'b1101101, 7'b0110000, 7'b1111110};
    localparam logic [6:0]            SEG_INV = SEG_ACTIVE_LOW != 0 ? 7'h7f : 7'h00;
    localparam logic                  DP_INV  = SEG_ACTIVE_LOW != 0;
    localparam logic [NUM_DIGITS-1:0] AN_INV  = AN_ACTIVE_LOW != 0 ? '1 : '0;

    logic [PW-1:0]           prescaler;
    logic [4*NUM_DIGITS-1:0] active_val, pend_val;
    logic [NUM_DIGITS-1:0]   active_dp, pend_dp, onehot;
    logic [3:0]              nib;
    logic [6:0]              seg_lit;
    logic                    tick, wrap, blank;

    assign tick   = enable && prescaler == PW'(CLK_DIV - 1);
    assign wrap   = tick && digit_idx == IW'(NUM_DIGITS - 1);
    assign nib    = active_val[{digit_idx, 2'b00} +: 4];
    // current digit and everything above it zero; digit 0 always shows
    assign blank  = lzb && digit_idx != '0 && (active_val >> {digit_idx, 2'b00}) == '0;
    assign seg_lit = blank ? 7'd0 : SEG_LUT[nib * 7 +: 7];
    assign onehot = NUM_DIGITS'(1) << digit_idx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prescaler  <= '0;
            digit_idx  <= '0;
            active_val <= '0;
            active_dp  <= '0;
            pend_val   <= '0;
            pend_dp    <= '0;
            pending    <= 1'b0;
            frame_done <= 1'b0;
            seg        <= SEG_INV;
            dp         <= DP_INV;
            an         <= AN_INV;
        end else begin
            prescaler  <= (!enable || tick) ? '0 : prescaler + PW'(1);
            digit_idx  <= !enable ? '0 : wrap ? '0 : tick ? digit_idx + IW'(1) : digit_idx;
            frame_done <= wrap;
            // commit takes the pre-existing pending contents; a coinciding load waits a frame
            if (wrap && pending) begin
                active_val <= pend_val;
                active_dp  <= pend_dp;
            end
            if (load) begin
                pend_val <= value;
                pend_dp  <= dp_mask;
            end
            pending <= load || (pending && !wrap);
            seg     <= enable ? seg_lit ^ SEG_INV : SEG_INV;
            dp      <= enable ? active_dp[digit_idx] ^ DP_INV : DP_INV;
            an      <= (enable && prescaler >= PW'(GUARD)) ? onehot ^ AN_INV : AN_INV;
        end
    end
endmodule

// File: tb/tb_seg7_mux_scan_driver.sv
// tb_seg7_mux_scan_driver: randomized and directed checks of both polarities against a slot-position model
module tb_seg7_mux_scan_driver;
    localparam int ND = 4, CD = 4, GD = 1;
    localparam logic [6:0] DEC [16] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
                                        7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
                                        7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
                                        7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111};
    logic clk = 0, rst_n = 0, enable = 0, load = 0, lzb = 0, run_cmp = 0;
    logic [15:0] value = 0;
    logic [3:0]  dp_mask = 0;
    logic [6:0]  seg0, seg1;
    logic        dp0, dp1, fd0, fd1, pnd0, pnd1;
    logic [3:0]  an0, an1;
    logic [1:0]  idx0, idx1;
    int errs = 0, total = 0;

    int          pos;
    logic [15:0] m_act, m_pv;
    logic [3:0]  m_adp, m_pdp, e_an, e_ann;
    logic [6:0]  e_seg, e_segn;
    logic [1:0]  m_idx;
    logic        e_dp, e_dpn, e_fd, m_pnd;
    assign e_segn = ~e_seg;
    assign e_dpn  = ~e_dp;
    assign e_ann  = ~e_an;

    seg7_mux_scan_driver #(.NUM_DIGITS(ND), .CLK_DIV(CD), .GUARD(GD), .SEG_ACTIVE_LOW(0), .AN_ACTIVE_LOW(0)) u0 (
        .clk(clk), .rst_n(rst_n), .enable(enable), .load(load), .value(value), .dp_mask(dp_mask), .lzb(lzb),
        .seg(seg0), .dp(dp0), .an(an0), .digit_idx(idx0), .frame_done(fd0), .pending(pnd0));
    seg7_mux_scan_driver #(.NUM_DIGITS(ND), .CLK_DIV(CD), .GUARD(GD), .SEG_ACTIVE_LOW(1), .AN_ACTIVE_LOW(1)) u1 (
        .clk(clk), .rst_n(rst_n), .enable(enable), .load(load), .value(value), .dp_mask(dp_mask), .lzb(lzb),
        .seg(seg1), .dp(dp1), .an(an1), .digit_idx(idx1), .frame_done(fd1), .pending(pnd1));

    always #5 clk = ~clk;

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endfunction

    function automatic bit hi_zero(input logic [15:0] v, input int d);
        for (int j = d; j < ND; j++) if (v[4*j +: 4] != 4'd0) return 0;
        return 1;
    endfunction

    // model: slot position counted as cycles since scanning (re)started
    always @(posedge clk or negedge rst_n) begin
        int dg, ph;
        logic [6:0] s;
        logic wrap;
        if (!rst_n) begin
            pos <= 0; m_act <= 0; m_adp <= 0; m_pv <= 0; m_pdp <= 0; m_pnd <= 0; m_idx <= 0;
            e_seg <= 0; e_dp <= 0; e_an <= 0; e_fd <= 0;
        end else begin
            dg = (pos / CD) % ND;
            ph = pos % CD;
            wrap = enable && ph == CD - 1 && dg == ND - 1;
            s = (lzb && dg > 0 && hi_zero(m_act, dg)) ? 7'd0 : DEC[m_act[4*dg +: 4]];
            e_seg <= enable ? s : 7'd0;
            e_dp  <= enable && m_adp[dg];
            e_an  <= (enable && ph >= GD) ? 4'(1 << dg) : 4'd0;
            e_fd  <= wrap;
            m_idx <= enable ? 2'(((pos + 1) / CD) % ND) : 2'd0;
            pos   <= enable ? pos + 1 : 0;
            if (wrap && m_pnd) begin
                m_act <= m_pv;
                m_adp <= m_pdp;
            end
            if (load) begin
                m_pv  <= value;
                m_pdp <= dp_mask;
            end
            m_pnd <= load || (m_pnd && !wrap);
        end
    end

    always @(negedge clk) if (run_cmp) begin
        chk("seg", seg0, e_seg);      chk("seg_inv", seg1, e_segn);
        chk("dp", dp0, e_dp);         chk("dp_inv", dp1, e_dpn);
        chk("an", an0, e_an);         chk("an_inv", an1, e_ann);
        chk("digit_idx", idx0, m_idx); chk("digit_idx_inv", idx1, m_idx);
        chk("frame_done", fd0, e_fd); chk("frame_done_inv", fd1, e_fd);
        chk("pending", pnd0, m_pnd);  chk("pending_inv", pnd1, m_pnd);
    end

    task automatic do_load(input logic [15:0] v, input logic [3:0] d);
        @(negedge clk);
        value = v; dp_mask = d; load = 1;
        @(negedge clk);
        load = 0;
    endtask

    task automatic wait_fd();
        int n = 0;
        do begin @(negedge clk); n++; end while (!fd0 && n < 100);
        chk("frame_done timeout", 32'(fd0), 1);
    endtask

    // literal check of one whole frame after the loaded data has been committed
    task automatic check_frame(input string nm, input logic [27:0] segs, input logic [3:0] dps);
        int n = 0, s;
        logic [6:0] es;
        logic [3:0] oh;
        do begin @(negedge clk); n++; end while (!(fd0 && !pnd0) && n < 100);
        chk({nm, " commit timeout"}, 32'(fd0 && !pnd0), 1);
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            s = k / 4;
            es = segs[7*s +: 7];
            oh = 4'(1 << s);
            if (k % 4 == 0) begin
                chk({nm, " guard an"}, an0, 4'h0);
                chk({nm, " guard an_inv"}, an1, 4'hf);
            end else begin
                chk({nm, " seg"}, seg0, es);
                chk({nm, " seg_inv"}, seg1, 7'(~es));
                chk({nm, " an"}, an0, oh);
                chk({nm, " an_inv"}, an1, 4'(~oh));
                chk({nm, " dp"}, dp0, dps[s]);
                chk({nm, " dp_inv"}, dp1, !dps[s]);
            end
        end
    endtask

    initial begin
        int n;
        repeat (3) @(posedge clk);
        run_cmp = 1;
        @(negedge clk);
        chk("reset seg", seg0, 0);     chk("reset seg_inv", seg1, 7'h7f);
        chk("reset an", an0, 0);       chk("reset an_inv", an1, 4'hf);
        chk("reset dp_inv", dp1, 1);   chk("reset idx", idx0, 0);
        rst_n = 1; enable = 1;
        do_load(16'h12AF, 4'b0100);
        check_frame("hex", {7'b0110000, 7'b1101101, 7'b1110111, 7'b1000111}, 4'b0100);
        lzb = 1;
        do_load(16'h0030, 4'b0000);
        check_frame("lzb30", {7'b0000000, 7'b0000000, 7'b1111001, 7'b1111110}, 4'b0000);
        do_load(16'h0000, 4'b0000);
        check_frame("lzb0", {7'b0000000, 7'b0000000, 7'b0000000, 7'b1111110}, 4'b0000);
        lzb = 0;
        do_load(16'h8888, 4'b0000);
        check_frame("eights", {4{7'b1111111}}, 4'b0000);
        wait_fd();
        repeat (5) @(negedge clk);
        value = 16'h1234; dp_mask = 4'b0001; load = 1;
        @(negedge clk);
        load = 0;
        chk("mid-frame pending", pnd0, 1);
        wait_fd();
        chk("pending after commit", pnd0, 0);
        n = 0;
        do begin @(negedge clk); n++; end while (!fd0 && n < 100);
        chk("frame period", n, 16);
        repeat (15) @(negedge clk);
        value = 16'hABCD; load = 1;
        @(negedge clk);
        load = 0;
        chk("wrap-load frame_done", fd0, 1);
        chk("wrap-load pending kept", pnd0, 1);
        wait_fd();
        chk("deferred commit", pnd0, 0);
        do_load(16'h5555, 4'b1111);
        @(posedge clk);
        #2 rst_n = 0;
        #1;
        chk("async seg", seg0, 0);     chk("async seg_inv", seg1, 7'h7f);
        chk("async an", an0, 0);       chk("async an_inv", an1, 4'hf);
        chk("async dp", dp0, 0);       chk("async dp_inv", dp1, 1);
        chk("async idx", idx0, 0);     chk("async pending", pnd0, 0);
        @(negedge clk);
        rst_n = 1;
        @(negedge clk);
        chk("restart guard", an0, 0);
        @(negedge clk);
        chk("restart seg", seg0, 7'b1111110);
        chk("restart an", an0, 4'b0001);
        @(negedge clk);
        enable = 0;
        repeat (10) begin
            @(negedge clk);
            chk("disabled an", an0, 0);
            chk("disabled idx", idx0, 0);
            chk("disabled frame_done", fd0, 0);
        end
        enable = 1;
        @(negedge clk);
        chk("reenable guard", an0, 0);
        @(negedge clk);
        chk("reenable digit0", an0, 4'b0001);
        repeat (2000) begin
            @(negedge clk);
            enable  = $urandom_range(0, 19) != 0;
            load    = $urandom_range(0, 7) == 0;
            value   = 16'($urandom);
            dp_mask = 4'($urandom);
            if ($urandom_range(0, 31) == 0) lzb = ~lzb;
        end
        @(negedge clk);
        load = 0; enable = 1;
        repeat (40) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errs, total);
        $finish;
    end
endmodule
